// File: rtl/value_repacker_pkg.sv
// Shared types and widths for the value repacker: FIFO entry layout and packet FSM states.
package value_repacker_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int DATA_WIDTH = 7;
  localparam int ACC_WIDTH  = WORD_WIDTH + DATA_WIDTH - 1;
  localparam int BITS_WIDTH = 6;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic [BITS_WIDTH-1:0] bits;
    logic                  first;
    logic                  last;
  } fifo_entry_t;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } fsm_t;
endpackage

// File: rtl/value_repacker_fifo.sv
// Dual-push, single-pop word FIFO; a cycle may write 0, 1 or 2 entries, entry0 first.
module repack_fifo
  import value_repacker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   i_push_cnt,
  input  fifo_entry_t                  i_entry0,
  input  fifo_entry_t                  i_entry1,
  input  logic                         i_pop_ready,
  output fifo_entry_t                  o_head,
  output logic                         o_valid,
  output logic [$clog2(DEPTH):0]       o_free
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_entry_t    r_mem [DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [CW-1:0]  r_count;

  logic [CW-1:0]  w_free;
  logic [CW-1:0]  w_accept_cnt;
  logic           w_pop;

  // Free space is taken from the registered count, so a same-cycle pop does not make room.
  always_comb begin
    w_free       = CW'(DEPTH) - r_count;
    w_accept_cnt = (CW'(i_push_cnt) > w_free) ? w_free : CW'(i_push_cnt);
    w_pop        = (r_count != '0) && i_pop_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + AW'(w_accept_cnt);
      r_rd    <= r_rd + AW'(w_pop);
      r_count <= r_count + w_accept_cnt - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept_cnt >= CW'(1)) r_mem[r_wr] <= i_entry0;
    if (w_accept_cnt >= CW'(2)) r_mem[r_wr + AW'(1)] <= i_entry1;
  end

  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rd] : '0;
  assign o_free  = w_free;
endmodule

// File: rtl/value_repacker.sv
// Packs 7-bit serializer values LSB-first into 32-bit words and flushes a partial word on packet end.
module value_repacker
  import value_repacker_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  first_in,
  input  logic                  last_in,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic [5:0]            word_bits,
  output logic                  word_first,
  output logic                  word_last,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  overflow_err,
  output logic                  proto_err,
  output fsm_t                  dbg_state
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Output handshake: the head word transfers on a clock edge where word_valid and word_ready are both 1;
  // word_valid never depends on word_ready, and the head stays stable until it transfers.

  fsm_t                 r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [5:0]           r_bits;
  logic                 r_first_pending;
  logic                 r_overflow;
  logic                 r_proto;

  logic                 w_start;
  logic                 w_accept;
  logic                 w_proto;
  logic [ACC_WIDTH-1:0] w_base_acc;
  logic [5:0]           w_base_bits;
  logic                 w_base_first;
  logic [ACC_WIDTH-1:0] w_acc_n;
  logic [5:0]           w_bits_n;
  logic                 w_full;
  logic [ACC_WIDTH-1:0] w_rem_acc;
  logic [5:0]           w_rem_bits;
  logic                 w_flush;
  fifo_entry_t          w_full_entry;
  fifo_entry_t          w_rem_entry;
  fifo_entry_t          w_entry0;
  logic [1:0]           w_push_cnt;
  logic                 w_drop;
  fifo_entry_t          w_head;
  logic [CW-1:0]        w_free;

  always_comb begin
    w_start  = valid_in & first_in;
    w_accept = valid_in & (first_in | (r_state == IN_PKT));
    // A stray value outside a packet, or a restart that abandons a partial packet, is a framing error.
    w_proto  = valid_in & (first_in ? (r_state == IN_PKT) : (r_state == IDLE));

    w_base_acc   = w_start ? '0 : r_acc;
    w_base_bits  = w_start ? '0 : r_bits;
    w_base_first = w_start | r_first_pending;

    w_acc_n    = w_base_acc | (ACC_WIDTH'(data_in) << w_base_bits);
    w_bits_n   = w_base_bits + 6'(DATA_WIDTH);
    w_full     = (w_bits_n >= 6'(WORD_WIDTH));
    w_rem_acc  = w_full ? (w_acc_n >> WORD_WIDTH) : w_acc_n;
    w_rem_bits = w_full ? (w_bits_n - 6'(WORD_WIDTH)) : w_bits_n;
    w_flush    = w_accept & last_in & (w_rem_bits != '0);

    w_full_entry = '{data:  w_acc_n[WORD_WIDTH-1:0],
                     bits:  6'(WORD_WIDTH),
                     first: w_base_first,
                     last:  last_in & (w_rem_bits == '0)};
    w_rem_entry  = '{data:  w_rem_acc[WORD_WIDTH-1:0],
                     bits:  w_rem_bits,
                     first: w_base_first & ~w_full,
                     last:  1'b1};

    w_entry0   = w_full ? w_full_entry : w_rem_entry;
    w_push_cnt = 2'(w_accept & w_full) + 2'(w_flush);
    w_drop     = (CW'(w_push_cnt) > w_free);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_acc           <= '0;
      r_bits          <= '0;
      r_first_pending <= 1'b0;
      r_overflow      <= 1'b0;
      r_proto         <= 1'b0;
    end else begin
      if (w_proto) r_proto    <= 1'b1;
      if (w_drop)  r_overflow <= 1'b1;
      if (w_accept) begin
        if (last_in) begin
          r_acc           <= '0;
          r_bits          <= '0;
          r_first_pending <= 1'b0;
          r_state         <= IDLE;
        end else begin
          r_acc           <= w_rem_acc;
          r_bits          <= w_rem_bits;
          r_first_pending <= w_base_first & ~w_full;
          r_state         <= IN_PKT;
        end
      end
    end
  end

  repack_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push_cnt  (w_push_cnt),
    .i_entry0    (w_entry0),
    .i_entry1    (w_rem_entry),
    .i_pop_ready (word_ready),
    .o_head      (w_head),
    .o_valid     (word_valid),
    .o_free      (w_free)
  );

  assign word_out     = w_head.data;
  assign word_bits    = w_head.bits;
  assign word_first   = w_head.first;
  assign word_last    = w_head.last;
  assign overflow_err = r_overflow;
  assign proto_err    = r_proto;
  assign dbg_state    = r_state;
endmodule
